digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/scan_pkg.sv | 21 ++
 rtl/mask_next_idx.sv | 37 +++
 rtl/digit_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the multiplexed digit scan controller.
//   scan_state_e : FSM state encoding (IDLE=0, SHOW=1, BLANK=2)
//   DWELL_W      : width of the per-digit dwell down-counter
//   BLANK_W      : width of the inter-digit blank down-counter
// ---------------------------------------------------------------------------
package scan_pkg;

    // The state names carry an S_ prefix so they never collide with the
    // BLANK parameter of the controller.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_BLANK = 2'd2
    } scan_state_e;

    localparam int DWELL_W = 16;
    localparam int BLANK_W = 8;

endpackage

// File: rtl/mask_next_idx.sv
// ---------------------------------------------------------------------------
// mask_next_idx
// Combinational search for the circularly next set bit of an 8-bit mask,
// strictly above the current index and wrapping 7->0.
//   mask [7:0] : in  - digits taking part in the scan
//   cur  [2:0] : in  - current digit index
//   nxt  [2:0] : out - next set bit index (0 when the mask is empty)
//   wrap       : out - 1 when nxt <= cur, i.e. the scan started over
//   none       : out - 1 when the mask has no set bit
// ---------------------------------------------------------------------------
module mask_next_idx (
    input  logic [7:0] mask,
    input  logic [2:0] cur,
    output logic [2:0] nxt,
    output logic       wrap,
    output logic       none
);

    logic found;

    // Walk offsets 1..8 from cur. The 3-bit sum wraps modulo 8, so offset 8
    // lands back on cur itself, which is how a single-bit mask finds itself
    // and reports a wrap.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (!found && mask[cur + 3'(k)]) begin
                nxt   = cur + 3'(k);
                found = 1'b1;
            end
        end
        none = ~|mask;
        wrap = found && (nxt <= cur);
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// digit_scan_ctrl
// Time-multiplexed digit scanner: shows each enabled digit for DWELL cycles,
// separated by BLANK dark cycles, and pulses frame_done when the scan wraps.
//   clk        : in  - clock, rising edge
//   rst_n      : in  - synchronous active-low reset
//   run        : in  - scan enable; low forces IDLE
//   digit_mask : in  - bit i set means digit i is scanned
//   sel  [2:0] : out - digit index to the 3-to-8 decoder
//   sel_en     : out - decoder enable, high only while showing a digit
//   frame_done : out - one-cycle pulse on the first SHOW cycle after a wrap
// ---------------------------------------------------------------------------
module digit_scan_ctrl
    import scan_pkg::*;
#(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned BLANK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [7:0] digit_mask,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic       frame_done
);

    localparam bit                 HAS_BLANK  = (BLANK != 0);
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = HAS_BLANK ? BLANK_W'(BLANK - 1) : '0;

    scan_state_e        state_q, state_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [2:0]         sel_q, sel_d;
    logic               sel_en_q, sel_en_d;
    logic               frame_done_q, frame_done_d;

    logic [2:0] cur_idx;
    logic [2:0] nxt_idx;
    logic       nxt_wrap;
    logic       mask_none;
    logic       dwell_end;
    logic       blank_end;

    // Searching from index 7 makes the "next" bit the lowest set bit, so a
    // single search unit serves both the start from IDLE and digit advance.
    assign cur_idx = (state_q == S_IDLE) ? 3'd7 : sel_q;

    mask_next_idx u_next (
        .mask (digit_mask),
        .cur  (cur_idx),
        .nxt  (nxt_idx),
        .wrap (nxt_wrap),
        .none (mask_none)
    );

    assign dwell_end = (state_q == S_SHOW)  && (dwell_cnt_q == '0);
    assign blank_end = (state_q == S_BLANK) && (blank_cnt_q == '0);

    // State, counter and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            dwell_cnt_q  <= '0;
            blank_cnt_q  <= '0;
            sel_q        <= '0;
            sel_en_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_cnt_q  <= dwell_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
            sel_q        <= sel_d;
            sel_en_q     <= sel_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic. The mask is only consulted when leaving IDLE or at a
    // digit boundary, so edits mid-dwell never shorten the current digit.
    always_comb begin
        state_d = state_q;
        if (!run) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!mask_none) state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (dwell_end) begin
                        if (HAS_BLANK)      state_d = S_BLANK;
                        else if (mask_none) state_d = S_IDLE;
                        else                state_d = S_SHOW;
                    end
                end
                S_BLANK: begin
                    if (blank_end) state_d = mask_none ? S_IDLE : S_SHOW;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Counter and output next values. Outputs are registered copies of what
    // the next state implies, so sel_en is high exactly in SHOW.
    always_comb begin
        dwell_cnt_d  = dwell_cnt_q;
        blank_cnt_d  = blank_cnt_q;
        sel_d        = sel_q;
        sel_en_d     = (state_d == S_SHOW);
        frame_done_d = 1'b0;
        if (!run) begin
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (state_d == S_SHOW) begin
                        sel_d       = nxt_idx;
                        dwell_cnt_d = DWELL_LOAD;
                    end
                end
                S_SHOW: begin
                    if (!dwell_end) begin
                        dwell_cnt_d = dwell_cnt_q - 1'b1;
                    end else if (HAS_BLANK) begin
                        blank_cnt_d = BLANK_LOAD;
                    end else if (state_d == S_SHOW) begin
                        sel_d        = nxt_idx;
                        frame_done_d = nxt_wrap;
                        dwell_cnt_d  = DWELL_LOAD;
                    end
                end
                S_BLANK: begin
                    if (!blank_end) begin
                        blank_cnt_d = blank_cnt_q - 1'b1;
                    end else if (state_d == S_SHOW) begin
                        sel_d        = nxt_idx;
                        frame_done_d = nxt_wrap;
                        dwell_cnt_d  = DWELL_LOAD;
                    end
                end
                default: begin
                    dwell_cnt_d = '0;
                    blank_cnt_d = '0;
                end
            endcase
        end
    end

    assign sel        = sel_q;
    assign sel_en     = sel_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_digit_scan_ctrl
// Self-checking bench: exhaustive check of mask_next_idx against a reference
// search, a cycle table for DWELL=3/BLANK=1, and a BLANK=0 single-digit run.
// ---------------------------------------------------------------------------
module tb_digit_scan_ctrl;

    typedef struct {
        logic       rstN;
        logic       run;
        logic [7:0] mask;
        logic [2:0] sel;
        logic       en;
        logic       fd;
    } vec_t;

    typedef struct {
        int         dutId;
        int         step;
        logic [2:0] sel;
        logic       en;
        logic       fd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [7:0] mask = 8'h00;
    logic [2:0] sel;
    logic       selEn;
    logic       frameDone;

    logic       run0 = 1'b0;
    logic [7:0] mask0 = 8'h00;
    logic [2:0] sel0;
    logic       selEn0;
    logic       frameDone0;

    logic [7:0] mniMask = 8'h00;
    logic [2:0] mniCur = 3'd0;
    logic [2:0] mniNxt;
    logic       mniWrap;
    logic       mniNone;

    vec_t vecs[$];
    exp_t expQ[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    digit_scan_ctrl #(.DWELL(3), .BLANK(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .digit_mask (mask),
        .sel        (sel),
        .sel_en     (selEn),
        .frame_done (frameDone)
    );

    digit_scan_ctrl #(.DWELL(3), .BLANK(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run0),
        .digit_mask (mask0),
        .sel        (sel0),
        .sel_en     (selEn0),
        .frame_done (frameDone0)
    );

    mask_next_idx u_mni (
        .mask (mniMask),
        .cur  (mniCur),
        .nxt  (mniNxt),
        .wrap (mniWrap),
        .none (mniNone)
    );

    task automatic addVec(input logic rstN, input logic r, input logic [7:0] m,
                          input logic [2:0] s, input logic e, input logic f);
        vec_t v;
        v.rstN = rstN; v.run = r; v.mask = m; v.sel = s; v.en = e; v.fd = f;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs on the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic applyStimulus(input int dutId, input int step, input logic rstN,
                                 input logic r, input logic [7:0] m,
                                 input logic [2:0] s, input logic e, input logic f);
        exp_t ex;
        @(negedge clk);
        rst_n = rstN;
        if (dutId == 0) begin
            run  = r;
            mask = m;
        end else begin
            run0  = r;
            mask0 = m;
        end
        ex.dutId = dutId; ex.step = step; ex.sel = s; ex.en = e; ex.fd = f;
        expQ.push_back(ex);
    endtask

    // Sample just after the rising edge and retire every queued expectation.
    task automatic checkOutput();
        exp_t       ex;
        logic [2:0] gotSel;
        logic       gotEn;
        logic       gotFd;
        @(posedge clk);
        #1;
        while (expQ.size() > 0) begin
            ex = expQ.pop_front();
            if (ex.dutId == 0) begin
                gotSel = sel;  gotEn = selEn;  gotFd = frameDone;
            end else begin
                gotSel = sel0; gotEn = selEn0; gotFd = frameDone0;
            end
            total++;
            if (gotSel !== ex.sel || gotEn !== ex.en || gotFd !== ex.fd) begin
                bad++;
                $display("[TB] FAIL scan dut%0d step%0d: got sel=%0d en=%0b fd=%0b, want sel=%0d en=%0b fd=%0b",
                         ex.dutId, ex.step, gotSel, gotEn, gotFd, ex.sel, ex.en, ex.fd);
            end
        end
    endtask

    initial begin
        logic [7:0] mv;
        logic [2:0] refNxt;
        logic       refWrap;
        logic       refNone;
        logic       found;

        // Reference search: upward from cur+1 to 7, then from 0 up to cur.
        for (int m = 0; m < 256; m++) begin
            for (int c = 0; c < 8; c++) begin
                mv      = 8'(m);
                mniMask = mv;
                mniCur  = 3'(c);
                #1;
                found   = 1'b0;
                refNxt  = 3'd0;
                refWrap = 1'b0;
                refNone = (mv == 8'h00);
                for (int j = c + 1; j < 8; j++) begin
                    if (!found && mv[j]) begin refNxt = 3'(j); found = 1'b1; end
                end
                for (int j = 0; j <= c; j++) begin
                    if (!found && mv[j]) begin refNxt = 3'(j); found = 1'b1; refWrap = 1'b1; end
                end
                total++;
                if (mniNxt !== refNxt || mniWrap !== refWrap || mniNone !== refNone) begin
                    bad++;
                    $display("[TB] FAIL mask_next_idx mask=%02h cur=%0d: got nxt=%0d wrap=%0b none=%0b, want nxt=%0d wrap=%0b none=%0b",
                             mv, c, mniNxt, mniWrap, mniNone, refNxt, refWrap, refNone);
                end
            end
        end

        // Cycle table for DWELL=3, BLANK=1: rst_n, run, mask -> sel, sel_en, frame_done
        addVec(0, 0, 8'h05, 0, 0, 0);  // reset
        addVec(1, 0, 8'h05, 0, 0, 0);  // idle, run low
        addVec(1, 1, 8'h05, 0, 1, 0);  // first SHOW, no frame_done
        addVec(1, 1, 8'h05, 0, 1, 0);
        addVec(1, 1, 8'h05, 0, 1, 0);
        addVec(1, 1, 8'h05, 0, 0, 0);  // blank
        addVec(1, 1, 8'h05, 2, 1, 0);
        addVec(1, 1, 8'h05, 2, 1, 0);
        addVec(1, 1, 8'h05, 2, 1, 0);
        addVec(1, 1, 8'h05, 2, 0, 0);
        addVec(1, 1, 8'h05, 0, 1, 1);  // wrap back to 0
        addVec(1, 1, 8'h05, 0, 1, 0);
        addVec(1, 1, 8'h05, 0, 1, 0);
        addVec(1, 1, 8'h05, 0, 0, 0);
        addVec(1, 1, 8'h05, 2, 1, 0);
        addVec(1, 1, 8'h05, 2, 1, 0);
        addVec(1, 1, 8'h05, 2, 1, 0);
        addVec(1, 1, 8'h05, 2, 0, 0);
        addVec(1, 1, 8'h05, 0, 1, 1);
        addVec(1, 1, 8'h0C, 0, 1, 0);  // mask edit mid-dwell
        addVec(1, 1, 8'h0C, 0, 1, 0);
        addVec(1, 1, 8'h0C, 0, 0, 0);
        addVec(1, 1, 8'h0C, 2, 1, 0);
        addVec(1, 1, 8'h0C, 2, 1, 0);
        addVec(1, 1, 8'h0C, 2, 1, 0);
        addVec(1, 1, 8'h0C, 2, 0, 0);
        addVec(1, 1, 8'h0C, 3, 1, 0);
        addVec(1, 1, 8'h0C, 3, 1, 0);
        addVec(1, 1, 8'h0C, 3, 1, 0);
        addVec(1, 1, 8'h0C, 3, 0, 0);
        addVec(1, 1, 8'h0C, 2, 1, 1);  // wrap 3 -> 2
        addVec(1, 1, 8'h00, 2, 1, 0);  // mask cleared mid-dwell
        addVec(1, 1, 8'h00, 2, 1, 0);
        addVec(1, 1, 8'h00, 2, 0, 0);
        addVec(1, 1, 8'h00, 2, 0, 0);  // idle, no frame_done
        addVec(1, 1, 8'h00, 2, 0, 0);
        addVec(1, 1, 8'h12, 1, 1, 0);  // restart at lowest bit
        addVec(1, 1, 8'h12, 1, 1, 0);
        addVec(1, 0, 8'h12, 1, 0, 0);  // run dropped mid-SHOW
        addVec(1, 0, 8'h12, 1, 0, 0);
        addVec(1, 1, 8'h12, 1, 1, 0);
        addVec(1, 1, 8'h12, 1, 1, 0);
        addVec(1, 1, 8'h12, 1, 1, 0);
        addVec(1, 1, 8'h12, 1, 0, 0);
        addVec(0, 1, 8'h12, 0, 0, 0);  // reset mid-BLANK
        addVec(1, 1, 8'h12, 1, 1, 0);
        addVec(1, 1, 8'h12, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(0, i, vecs[i].rstN, vecs[i].run, vecs[i].mask,
                          vecs[i].sel, vecs[i].en, vecs[i].fd);
            checkOutput();
        end

        // BLANK=0 with a single digit: continuous sel_en, frame_done every
        // DWELL cycles except on the first SHOW after IDLE.
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1, k, 1'b1, 1'b1, 8'h80, 3'd7, 1'b1,
                          (k > 1) && ((k - 1) % 3 == 0));
            checkOutput();
        end
        applyStimulus(1, 13, 1'b1, 1'b0, 8'h80, 3'd7, 1'b0, 1'b0);
        checkOutput();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
